gol_frame_streamer: RTL and testbench

GOL_FRAME_STREAMER -- requirements
Module: gol_frame_streamer

---
 rtl/gol_pkg.sv | 19 +
 rtl/gol_popcount64.sv | 16 +
 rtl/gol_frame_streamer.sv | 130 +++++++++++++
 tb/tb_gol_frame_streamer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and sizing for the Game-of-Life frame streamer.
package gol_pkg;

   localparam int unsigned BOARD_W  = 64;
   localparam int unsigned ROW_W    = 8;
   localparam int unsigned NUM_ROWS = 8;
   localparam int unsigned IDX_W    = $clog2(NUM_ROWS);
   localparam int unsigned POP_W    = $clog2(BOARD_W) + 1;

   localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_ROWS - 1);

   typedef enum logic [0:0] {
      StIdle,
      StStream
   } state_e;

   typedef logic [BOARD_W-1:0] board_t;

endpackage

// File: rtl/gol_popcount64.sv
// Combinational population count of a 64-bit board.
module gol_popcount64
   import gol_pkg::*;
(
   input  board_t           board,
   output logic [POP_W-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < BOARD_W; i++) begin
         count = count + POP_W'(board[i]);
      end
   end

endmodule

// File: rtl/gol_frame_streamer.sv
// Streams 8x8 Game-of-Life boards row by row, with one pending board slot and
// per-frame statistics (live cells, still-life detection, generation count).
module gol_frame_streamer
   import gol_pkg::*;
#(
   parameter int unsigned GEN_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              board_valid,
   input  board_t            board,
   output logic              board_ready,
   output logic              row_valid,
   output logic [ROW_W-1:0]  row_data,
   output logic [IDX_W-1:0]  row_idx,
   output logic              row_last,
   input  logic              row_ready,
   output logic [POP_W-1:0]  live_count,
   output logic              still_life,
   output logic [GEN_W-1:0]  gen_count
);

   state_e             state_q, state_d;
   board_t             f_q, f_d, p_q, p_d;
   logic               p_full_q, p_full_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [POP_W-1:0]   live_q, live_d;
   logic               still_q, still_d;
   logic [GEN_W-1:0]   gen_q, gen_d;

   logic               accept, row_hs, last_hs;
   logic               load_from_p, load_from_board, load_p, f_load;
   board_t             new_f;
   logic [POP_W-1:0]   new_pop;

   gol_popcount64 u_popcount (
      .board (new_f),
      .count (new_pop)
   );

   // board_ready is purely a register output, so accept never depends on row_ready.
   always_comb begin
      accept          = board_valid && !p_full_q;
      row_hs          = (state_q == StStream) && row_ready;
      last_hs         = row_hs && (idx_q == LAST_ROW);
      load_from_p     = last_hs && p_full_q;
      load_from_board = accept && ((state_q == StIdle) || last_hs);
      load_p          = accept && (state_q == StStream) && !last_hs;
      f_load          = load_from_p || load_from_board;
      new_f           = load_from_p ? p_q : board;
   end

   always_comb begin
      state_d  = state_q;
      f_d      = f_q;
      p_d      = p_q;
      p_full_d = p_full_q;
      idx_d    = idx_q;
      live_d   = live_q;
      still_d  = still_q;
      gen_d    = gen_q;

      if (f_load) begin
         f_d     = new_f;
         idx_d   = '0;
         live_d  = new_pop;
         still_d = (new_f == f_q) && (gen_q != '0);
         if (gen_q != {GEN_W{1'b1}}) begin
            gen_d = gen_q + 1'b1;
         end
      end else if (row_hs) begin
         idx_d = idx_q + 1'b1;
      end

      if (load_from_p) begin
         p_full_d = 1'b0;
      end else if (load_p) begin
         p_d      = board;
         p_full_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StStream;
            end
         end
         StStream: begin
            if (last_hs && !p_full_q && !accept) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         f_q      <= '0;
         p_q      <= '0;
         p_full_q <= 1'b0;
         idx_q    <= '0;
         live_q   <= '0;
         still_q  <= 1'b0;
         gen_q    <= '0;
      end else begin
         state_q  <= state_d;
         f_q      <= f_d;
         p_q      <= p_d;
         p_full_q <= p_full_d;
         idx_q    <= idx_d;
         live_q   <= live_d;
         still_q  <= still_d;
         gen_q    <= gen_d;
      end
   end

   always_comb begin
      board_ready = !p_full_q;
      row_valid   = (state_q == StStream);
      row_idx     = idx_q;
      row_last    = row_valid && (idx_q == LAST_ROW);
      row_data    = row_valid ? f_q[idx_q*ROW_W +: ROW_W] : '0;
      live_count  = live_q;
      still_life  = still_q;
      gen_count   = gen_q;
   end

endmodule

// File: tb/tb_gol_frame_streamer.sv
// Scoreboard bench: expected rows are queued on each board accept and popped on row handshakes.
module tb_gol_frame_streamer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        board_valid = 1'b0;
   logic [63:0] board = '0;
   logic        row_ready = 1'b1;

   logic        board_ready, row_valid, row_last, still_life;
   logic [7:0]  row_data;
   logic [2:0]  row_idx;
   logic [6:0]  live_count;
   logic [15:0] gen_count;

   logic        board_ready_s, row_valid_s, row_last_s, still_life_s;
   logic [7:0]  row_data_s;
   logic [2:0]  row_idx_s;
   logic [6:0]  live_count_s;
   logic [1:0]  gen_count_s;

   always #5 clk = ~clk;

   gol_frame_streamer #(.GEN_W(16)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .board_valid (board_valid),
      .board       (board),
      .board_ready (board_ready),
      .row_valid   (row_valid),
      .row_data    (row_data),
      .row_idx     (row_idx),
      .row_last    (row_last),
      .row_ready   (row_ready),
      .live_count  (live_count),
      .still_life  (still_life),
      .gen_count   (gen_count)
   );

   gol_frame_streamer #(.GEN_W(2)) u_dut_sat (
      .clk         (clk),
      .reset       (reset),
      .board_valid (board_valid),
      .board       (board),
      .board_ready (board_ready_s),
      .row_valid   (row_valid_s),
      .row_data    (row_data_s),
      .row_idx     (row_idx_s),
      .row_last    (row_last_s),
      .row_ready   (row_ready),
      .live_count  (live_count_s),
      .still_life  (still_life_s),
      .gen_count   (gen_count_s)
   );

   typedef struct packed {
      logic [7:0]  data;
      logic [2:0]  idx;
      logic        last;
      logic [6:0]  live;
      logic        still;
      logic [15:0] gen;
      logic [1:0]  gen_s;
   } exp_t;

   exp_t        sb[$];
   exp_t        e, got_e;
   int          total = 0;
   int          bad = 0;
   logic [63:0] mdl_prev = '0;
   logic [15:0] mdl_gen = '0;
   logic [1:0]  mdl_gen_s = '0;
   logic        st;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data;
   logic [2:0]  prev_idx;
   logic        prev_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         check("row_valid", {31'b0, row_valid}, {31'b0, sb.size() != 0});
         if (!row_valid) check("idle_data", {24'b0, row_data}, 32'h0);
         if (prev_stall) begin
            check("hold_data", {24'b0, row_data}, {24'b0, prev_data});
            check("hold_idx", {29'b0, row_idx}, {29'b0, prev_idx});
            check("hold_last", {31'b0, row_last}, {31'b0, prev_last});
         end
         if (row_valid && row_ready && sb.size() != 0) begin
            got_e = sb.pop_front();
            check("row_data", {24'b0, row_data}, {24'b0, got_e.data});
            check("row_idx", {29'b0, row_idx}, {29'b0, got_e.idx});
            check("row_last", {31'b0, row_last}, {31'b0, got_e.last});
            check("live_count", {25'b0, live_count}, {25'b0, got_e.live});
            check("still_life", {31'b0, still_life}, {31'b0, got_e.still});
            check("gen_count", {16'b0, gen_count}, {16'b0, got_e.gen});
            check("gen_count_sat", {30'b0, gen_count_s}, {30'b0, got_e.gen_s});
         end
         prev_stall = row_valid && !row_ready;
         prev_data  = row_data;
         prev_idx   = row_idx;
         prev_last  = row_last;
         if (board_valid && board_ready) begin
            st        = (board == mdl_prev) && (mdl_gen != 16'd0);
            mdl_gen   = mdl_gen + 16'd1;
            mdl_gen_s = (mdl_gen_s == 2'd3) ? 2'd3 : mdl_gen_s + 2'd1;
            for (int r = 0; r < 8; r++) begin
               e.data  = board[8*r +: 8];
               e.idx   = 3'(r);
               e.last  = (r == 7);
               e.live  = 7'($countones(board));
               e.still = st;
               e.gen   = mdl_gen;
               e.gen_s = mdl_gen_s;
               sb.push_back(e);
            end
            mdl_prev = board;
         end
      end
   end

   task automatic send_board(input logic [63:0] b);
      int   n = 0;
      logic ok = 1'b0;
      @(posedge clk);
      #1;
      board       = b;
      board_valid = 1'b1;
      while (!ok && n < 300) begin
         @(negedge clk);
         if (board_ready) ok = 1'b1;
         else n++;
      end
      check("send_timeout", {31'b0, ok}, 32'h1);
      @(posedge clk);
      #1;
      board_valid = 1'b0;
      board       = '0;
   endtask

   task automatic wait_drain();
      int   n = 0;
      logic ok = 1'b0;
      while (!ok && n < 1000) begin
         @(negedge clk);
         if (sb.size() == 0 && !row_valid) ok = 1'b1;
         else n++;
      end
      check("drain_timeout", {31'b0, ok}, 32'h1);
   endtask

   task automatic check_reset_state();
      check("rst_board_ready", {31'b0, board_ready}, 32'h1);
      check("rst_row_valid", {31'b0, row_valid}, 32'h0);
      check("rst_row_data", {24'b0, row_data}, 32'h0);
      check("rst_row_idx", {29'b0, row_idx}, 32'h0);
      check("rst_row_last", {31'b0, row_last}, 32'h0);
      check("rst_live", {25'b0, live_count}, 32'h0);
      check("rst_still", {31'b0, still_life}, 32'h0);
      check("rst_gen", {16'b0, gen_count}, 32'h0);
      check("rst_gen_sat", {30'b0, gen_count_s}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [63:0] tbl[3];
      int          n;
      logic        ok;

      repeat (3) @(negedge clk);
      check_reset_state();
      reset = 1'b1;

      // Blinker
      send_board(64'h0000_00e0_0000_0000);
      wait_drain();

      // Backpressure in frame cycles 3..6
      send_board(64'h0102_0408_1020_4080);
      repeat (3) @(posedge clk);
      #1 row_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1 row_ready = 1'b1;
      wait_drain();

      // Back-to-back: second board goes to the pending slot
      send_board(64'h1111_2222_3333_4444);
      send_board(64'h5555_6666_7777_8888);
      @(negedge clk);
      check("b2b_board_ready", {31'b0, board_ready}, 32'h0);
      send_board(64'h9999_aaaa_bbbb_cccc);
      wait_drain();

      // Still life
      send_board(64'h0000_0018_1800_0000);
      send_board(64'h0000_0018_1800_0000);
      wait_drain();

      // Full and empty boards
      tbl[0] = '1;
      tbl[1] = '0;
      tbl[2] = '0;
      for (int i = 0; i < 3; i++) send_board(tbl[i]);
      wait_drain();

      // Random boards under random backpressure
      fork
         begin
            repeat (4) send_board({$urandom, $urandom});
         end
         begin
            repeat (120) begin
               @(posedge clk);
               #1 row_ready = 1'($urandom_range(0, 1));
            end
            row_ready = 1'b1;
         end
      join
      wait_drain();

      // Reset in the middle of a frame
      send_board(64'hdead_beef_cafe_f00d);
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 100) begin
         @(negedge clk);
         if (row_valid && row_idx == 3'd4) ok = 1'b1;
         else n++;
      end
      check("row4_timeout", {31'b0, ok}, 32'h1);
      #1 reset = 1'b0;
      #1;
      check_reset_state();
      sb.delete();
      mdl_prev  = '0;
      mdl_gen   = '0;
      mdl_gen_s = '0;
      @(negedge clk);
      reset = 1'b1;

      // Five boards after reset: narrow counter saturates at 3
      for (int i = 0; i < 5; i++) send_board(64'h0f0f_0000_0000_f0f0 ^ 64'(i));
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
